// File: rtl/sweep_stim_checker_pkg.sv
// -----------------------------------------------------------------------------
// sweep_pkg
// Shared types and helpers for the exhaustive-sweep stimulus checker:
//   mode_t    - reference function selector (majority, exactly-one, odd parity,
//               all-zero)
//   state_t   - sweep sequencer states
//   popcount  - number of set bits in a vector of up to MAX_WIDTH bits
// -----------------------------------------------------------------------------
package sweep_pkg;

  localparam int MAX_WIDTH = 16;

  typedef enum logic [1:0] {
    MODE_MAJ  = 2'd0,
    MODE_ONE  = 2'd1,
    MODE_PAR  = 2'd2,
    MODE_ZERO = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  function automatic logic [4:0] popcount(input logic [MAX_WIDTH-1:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < MAX_WIDTH; i++) c = c + 5'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/sweep_stim_checker_if.sv
// -----------------------------------------------------------------------------
// sweep_stim_checker_if
// Bundles the control, stimulus and result signals of sweep_stim_checker.
//   slave  - the checker: takes start/mode/dut_y, drives stim and results
//   master - the environment: drives start/mode/dut_y, observes the rest
// Parameters: WIDTH (stimulus width), ERR_W (error counter width).
// -----------------------------------------------------------------------------
interface sweep_stim_checker_if #(
  parameter int WIDTH = 3,
  parameter int ERR_W = 8
);
  logic             start;
  logic [1:0]       mode;
  logic [WIDTH-1:0] stim;
  logic             dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [WIDTH-1:0] first_err_vec;
  logic             first_err_valid;

  modport master (
    output start, mode, dut_y,
    input  stim, busy, done, pass, err_count, first_err_vec, first_err_valid
  );

  modport slave (
    input  start, mode, dut_y,
    output stim, busy, done, pass, err_count, first_err_vec, first_err_valid
  );
endinterface

// File: rtl/sweep_stim_checker_ref_model.sv
// -----------------------------------------------------------------------------
// sweep_ref_model
// Purely combinational golden function for a WIDTH-bit gate under test.
//   i_mode     - MODE_MAJ: ones > WIDTH/2, MODE_ONE: exactly one bit set,
//                MODE_PAR: odd parity, MODE_ZERO: all bits zero
//   i_vec      - input vector applied to the gate
//   o_expected - expected gate output
// -----------------------------------------------------------------------------
module sweep_ref_model
  import sweep_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  mode_t            i_mode,
  input  logic [WIDTH-1:0] i_vec,
  output logic             o_expected
);

  logic [4:0] w_ones;

  assign w_ones = popcount(MAX_WIDTH'(i_vec));

  // NOTE: default assignment first so every path writes o_expected; no latch.
  always_comb begin
    o_expected = 1'b0;
    case (i_mode)
      MODE_MAJ:  o_expected = (w_ones > 5'(WIDTH / 2));
      MODE_ONE:  o_expected = (w_ones == 5'd1);
      MODE_PAR:  o_expected = w_ones[0];
      MODE_ZERO: o_expected = (w_ones == 5'd0);
      default:   o_expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/sweep_stim_checker.sv
// -----------------------------------------------------------------------------
// sweep_stim_checker
// Walks every WIDTH-bit vector onto a gate under test, holds each for DWELL
// cycles, samples dut_y at dwell index SETTLE and compares it with the
// reference function chosen by mode (latched at start).
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset
//   bus   - sweep_stim_checker_if.slave: start, mode, dut_y in;
//           stim, busy, done, pass, err_count, first_err_vec,
//           first_err_valid out (all registered)
// Optional: define SWEEP_GRAY_EN to visit the vectors in Gray-code order.
// -----------------------------------------------------------------------------
module sweep_stim_checker
  import sweep_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int DWELL  = 4,
  parameter int SETTLE = 2,
  parameter int ERR_W  = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  sweep_stim_checker_if.slave  bus
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH || DWELL < 2 || SETTLE < 0 || SETTLE >= DWELL)
  begin : g_bad_params
    $fatal(1, "sweep_stim_checker: illegal WIDTH/DWELL/SETTLE combination");
  end

  localparam int               DW_W        = $clog2(DWELL);
  localparam logic [WIDTH:0]   IDX_LAST    = (WIDTH + 1)'((1 << WIDTH) - 1);
  localparam logic [DW_W-1:0]  DWELL_LAST  = DW_W'(DWELL - 1);
  localparam logic [DW_W-1:0]  SETTLE_AT   = DW_W'(SETTLE);
  localparam logic [ERR_W-1:0] ERR_MAX     = '1;

  function automatic logic [WIDTH-1:0] vec_of(input logic [WIDTH-1:0] i);
`ifdef SWEEP_GRAY_EN
    return i ^ (i >> 1);
`else
    return i;
`endif
  endfunction

  state_t           r_state;
  mode_t            r_mode;
  // One bit wider than the vector so the final index never wraps to zero.
  logic [WIDTH:0]   r_idx;
  logic [DW_W-1:0]  r_dwell;
  logic [WIDTH-1:0] r_stim;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err_count;
  logic [WIDTH-1:0] r_first_err_vec;
  logic             r_first_err_valid;

  logic             w_expected;
  logic             w_mismatch;
  logic [ERR_W-1:0] w_err_next;
  logic [WIDTH:0]   w_idx_next;

  sweep_ref_model #(.WIDTH(WIDTH)) u_ref (
    .i_mode     (r_mode),
    .i_vec      (r_stim),
    .o_expected (w_expected)
  );

  // Compare against the stim currently on the bus, even when the sample edge
  // is also the advance edge.
  assign w_mismatch = (r_state == S_DRIVE) && (r_dwell == SETTLE_AT) &&
                      (bus.dut_y != w_expected);
  assign w_err_next = (w_mismatch && r_err_count != ERR_MAX) ?
                      r_err_count + ERR_W'(1) : r_err_count;
  assign w_idx_next = r_idx + (WIDTH + 1)'(1);

  // NOTE: sequential state uses non-blocking assignments only, and the reset
  // branch is sampled on the clock edge (synchronous), clearing every register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_mode            <= MODE_MAJ;
      r_idx             <= '0;
      r_dwell           <= '0;
      r_stim            <= '0;
      r_busy            <= 1'b0;
      r_done            <= 1'b0;
      r_pass            <= 1'b0;
      r_err_count       <= '0;
      r_first_err_vec   <= '0;
      r_first_err_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state           <= S_DRIVE;
            r_mode            <= mode_t'(bus.mode);
            r_idx             <= '0;
            r_dwell           <= '0;
            r_stim            <= vec_of('0);
            r_busy            <= 1'b1;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_first_err_vec   <= '0;
            r_first_err_valid <= 1'b0;
          end
        end
        S_DRIVE: begin
          r_dwell     <= r_dwell + DW_W'(1);
          r_err_count <= w_err_next;
          if (w_mismatch && !r_first_err_valid) begin
            r_first_err_vec   <= r_stim;
            r_first_err_valid <= 1'b1;
          end
          if (r_dwell == DWELL_LAST) begin
            if (r_idx < IDX_LAST) begin
              r_idx   <= w_idx_next;
              r_dwell <= '0;
              r_stim  <= vec_of(w_idx_next[WIDTH-1:0]);
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_stim  <= '0;
              r_pass  <= (w_err_next == '0);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.stim            = r_stim;
  assign bus.busy            = r_busy;
  assign bus.done            = r_done;
  assign bus.pass            = r_pass;
  assign bus.err_count       = r_err_count;
  assign bus.first_err_vec   = r_first_err_vec;
  assign bus.first_err_valid = r_first_err_valid;

endmodule

// File: tb/tb_sweep_stim_checker.sv
// -----------------------------------------------------------------------------
// tb_sweep_stim_checker
// Three checkers share start/mode and a gate modelled as an 8-entry truth
// table (lut[stim]):
//   u_dut  - WIDTH=3, DWELL=4, SETTLE=2, ERR_W=8
//   u_sat  - same but ERR_W=2 (saturation)
//   u_coin - SETTLE=3 (sample and advance on the same edge)
// Expected results come from the reference rules applied to the visit order.
// -----------------------------------------------------------------------------
module tb_sweep_stim_checker;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] lut = 8'h00;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  sweep_stim_checker_if #(.WIDTH(3), .ERR_W(8)) if_a ();
  sweep_stim_checker_if #(.WIDTH(3), .ERR_W(2)) if_b ();
  sweep_stim_checker_if #(.WIDTH(3), .ERR_W(8)) if_c ();

  assign if_a.start = start;
  assign if_a.mode  = mode;
  assign if_a.dut_y = lut[if_a.stim];
  assign if_b.start = start;
  assign if_b.mode  = mode;
  assign if_b.dut_y = lut[if_b.stim];
  assign if_c.start = start;
  assign if_c.mode  = mode;
  assign if_c.dut_y = lut[if_c.stim];

  sweep_stim_checker #(.WIDTH(3), .DWELL(4), .SETTLE(2), .ERR_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .bus(if_a));
  sweep_stim_checker #(.WIDTH(3), .DWELL(4), .SETTLE(2), .ERR_W(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .bus(if_b));
  sweep_stim_checker #(.WIDTH(3), .DWELL(4), .SETTLE(3), .ERR_W(8)) u_coin (
    .clk(clk), .rst_n(rst_n), .bus(if_c));

  // Visit order of the sweep.
  function automatic logic [2:0] seq_at(input int k);
    logic [2:0] gray_tab [8];
    gray_tab = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd6, 3'd7, 3'd5, 3'd4};
`ifdef SWEEP_GRAY_EN
    return gray_tab[k];
`else
    return 3'(k);
`endif
  endfunction

  function automatic logic ref_bit(input logic [1:0] m, input logic [2:0] v);
    int ones;
    ones = $countones(v);
    case (m)
      2'd0:    return ones >= 2;
      2'd1:    return ones == 1;
      2'd2:    return (ones % 2) == 1;
      default: return v == 3'd0;
    endcase
  endfunction

  // Drives one complete sweep and checks sequence and final results.
  task automatic run_sweep(input string name, input logic [7:0] lut_i,
                           input logic [1:0] mode_i, input bit disturb);
    int         exp_err;
    logic [2:0] exp_first;
    logic       exp_fv;
    logic [2:0] v;
    exp_err = 0; exp_first = '0; exp_fv = 1'b0;
    for (int k = 0; k < 8; k++) begin
      v = seq_at(k);
      if (lut_i[v] != ref_bit(mode_i, v)) begin
        exp_err++;
        if (!exp_fv) begin exp_first = v; exp_fv = 1'b1; end
      end
    end

    @(negedge clk);
    lut = lut_i; mode = mode_i; start = 1'b1;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      start = disturb && (k == 12 || k == 20);
      if (disturb && k == 6) mode = ~mode_i;
      n_checks++;
      if (if_a.busy !== 1'b1 || if_a.stim !== seq_at(k / 4)) begin
        n_fail++;
        $display("FAIL %s seq[%0d]: got busy=%b stim=%0d expected busy=1 stim=%0d",
                 name, k, if_a.busy, if_a.stim, seq_at(k / 4));
      end
      if (k == 0) begin
        n_checks++;
        if (if_a.err_count !== 8'd0 || if_a.first_err_valid !== 1'b0 || if_a.done !== 1'b0) begin
          n_fail++;
          $display("FAIL %s start_clear: got err=%0d fv=%b done=%b expected 0/0/0",
                   name, if_a.err_count, if_a.first_err_valid, if_a.done);
        end
      end
    end
    @(negedge clk);
    n_checks++;
    if (if_a.busy !== 1'b0 || if_a.done !== 1'b1 || if_a.stim !== 3'd0) begin
      n_fail++;
      $display("FAIL %s end_state: got busy=%b done=%b stim=%0d expected 0/1/0",
               name, if_a.busy, if_a.done, if_a.stim);
    end
    n_checks++;
    if (if_a.err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL %s err_count: got %0d expected %0d", name, if_a.err_count, exp_err);
    end
    n_checks++;
    if (if_a.first_err_valid !== exp_fv || if_a.first_err_vec !== (exp_fv ? exp_first : 3'd0)) begin
      n_fail++;
      $display("FAIL %s first_err: got valid=%b vec=%0d expected valid=%b vec=%0d",
               name, if_a.first_err_valid, if_a.first_err_vec, exp_fv, exp_first);
    end
    n_checks++;
    if (if_a.pass !== (exp_err == 0)) begin
      n_fail++;
      $display("FAIL %s pass: got %b expected %b", name, if_a.pass, exp_err == 0);
    end
    n_checks++;
    if (if_b.err_count !== 2'(exp_err > 3 ? 3 : exp_err) || if_b.pass !== (exp_err == 0)) begin
      n_fail++;
      $display("FAIL %s sat_err: got err=%0d pass=%b expected err=%0d pass=%b",
               name, if_b.err_count, if_b.pass, exp_err > 3 ? 3 : exp_err, exp_err == 0);
    end
    n_checks++;
    if (if_c.err_count !== 8'(exp_err) || if_c.first_err_vec !== (exp_fv ? exp_first : 3'd0) ||
        if_c.done !== 1'b1) begin
      n_fail++;
      $display("FAIL %s coincide: got err=%0d vec=%0d done=%b expected err=%0d vec=%0d done=1",
               name, if_c.err_count, if_c.first_err_vec, if_c.done, exp_err, exp_first);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({if_a.stim, if_a.busy, if_a.done, if_a.pass, if_a.err_count,
         if_a.first_err_vec, if_a.first_err_valid} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got stim=%0d busy=%b done=%b pass=%b err=%0d vec=%0d fv=%b expected all 0",
               if_a.stim, if_a.busy, if_a.done, if_a.pass, if_a.err_count,
               if_a.first_err_vec, if_a.first_err_valid);
    end
    n_checks++;
    if (if_b.err_count !== 2'd0 || if_c.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_others: got sat_err=%0d coin_busy=%b expected 0/0",
               if_b.err_count, if_c.busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (if_a.busy !== 1'b0 || if_a.done !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_hold: got busy=%b done=%b expected 0/0", if_a.busy, if_a.done);
    end
  endtask

  task automatic test_majority();   run_sweep("majority",  8'hE8, 2'd0, 1'b0); endtask
  task automatic test_tied_zero();  run_sweep("tied0_maj", 8'h00, 2'd0, 1'b0); endtask
  task automatic test_tied_one();   run_sweep("tied1_one", 8'hFF, 2'd1, 1'b0); endtask
  task automatic test_saturate();   run_sweep("inv_par",   8'h69, 2'd2, 1'b0); endtask
  task automatic test_restart();    run_sweep("restart",   8'h01, 2'd3, 1'b0); endtask

  task automatic test_mid_reset();
    @(negedge clk);
    lut = 8'h00; mode = 2'd3; start = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_checks++;
    if (if_a.err_count !== 8'd1 || if_a.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: got err=%0d busy=%b expected 1/1", if_a.err_count, if_a.busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_checks++;
    if (if_a.stim !== 3'd0 || if_a.busy !== 1'b0 || if_a.err_count !== 8'd0 ||
        if_a.first_err_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got stim=%0d busy=%b err=%0d fv=%b expected 0/0/0/0",
               if_a.stim, if_a.busy, if_a.err_count, if_a.first_err_valid);
    end
    @(negedge clk);
    n_checks++;
    if (if_a.busy !== 1'b0 || if_a.done !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got busy=%b done=%b expected 0/0", if_a.busy, if_a.done);
    end
    run_sweep("after_reset_busy_start", 8'h00, 2'd0, 1'b1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++) begin
      run_sweep($sformatf("random%0d", n), 8'($urandom), 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_majority();
    test_tied_zero();
    test_tied_one();
    test_saturate();
    test_restart();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
